sram_byte_bridge: RTL and testbench

Byte-to-word bridge between the 65xx SoC external bus (19-bit byte address, 8-bit data, read/write strobes) and the board's 16-bit asynchronous SRAM (18-bit word address, CS/OE/WE, tristate data via the top-level IO cells). It serialises each CPU access into an SRAM pin sequence with programmable wait states. Byte writes are performed as read-modify-write, because the SRAM has no byte enables. It sits directly downstream of the SoC bus port and drives the SRAM pins and data-pin IO cells.

---
 rtl/sram_byte_bridge_if.sv | 21 ++
 rtl/sram_byte_bridge.sv | 192 +++++++++++++++++++
 tb/tb_sram_byte_bridge.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_byte_bridge_if.sv
// SoC-side byte request bus of the SRAM bridge.
// The master modport is the SoC bus port, the slave modport is the bridge.
interface sram_byte_bridge_if;
  logic [18:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_rd;
  logic        req_wr;
  logic [7:0]  req_rdata;
  logic        req_ack;
  logic        busy;

  modport master (
    output req_addr, req_wdata, req_rd, req_wr,
    input  req_rdata, req_ack, busy
  );

  modport slave (
    input  req_addr, req_wdata, req_rd, req_wr,
    output req_rdata, req_ack, busy
  );
endinterface

// File: rtl/sram_byte_bridge.sv
// Byte-wide SoC bus to 16-bit async SRAM bridge; byte writes are read-modify-write.
// Optional one-word cache is enabled by defining SRAM_WORD_CACHE_EN.
module sram_byte_bridge #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  sram_byte_bridge_if.slave   bus,
  output logic [17:0]         sram_adr,
  input  logic [15:0]         sram_dat_in,
  output logic [15:0]         sram_dat_out,
  output logic                sram_dat_oe,
  output logic                sram_cs_n,
  output logic                sram_oe_n,
  output logic                sram_we_n
);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_isWrite;
  logic        r_lane;
  logic [7:0]  r_wdata;
  logic [15:0] r_word;
  logic [17:0] r_adr;
  logic [15:0] r_datOut;
  logic        r_datOe;
  logic        r_csN;
  logic        r_oeN;
  logic        r_weN;
  logic [7:0]  r_rdata;
  logic        r_ack;
  logic        r_busy;

  logic        w_accept;
  logic        w_last;
  logic        w_rdHit;
  logic        w_wrHit;
  logic [15:0] w_cacheWord;
  logic [15:0] w_fetchMerged;

  function automatic logic [15:0] mergeByte(input logic [15:0] word, input logic lane,
                                            input logic [7:0] data);
    mergeByte = lane ? {data, word[7:0]} : {word[15:8], data};
  endfunction

  assign w_accept      = ((r_state == IDLE) || (r_state == ACK)) && (bus.req_rd || bus.req_wr);
  assign w_last        = (r_cnt == 4'(WAIT_CYCLES - 1));
  assign w_fetchMerged = mergeByte(sram_dat_in, r_lane, r_wdata);

`ifdef SRAM_WORD_CACHE_EN
  logic        r_cacheValid;
  logic [17:0] r_cacheTag;
  logic [15:0] r_cacheData;
  logic        w_hit;

  assign w_hit       = r_cacheValid && (r_cacheTag == bus.req_addr[18:1]);
  assign w_rdHit     = w_hit && !bus.req_wr;
  assign w_wrHit     = w_hit && bus.req_wr;
  assign w_cacheWord = r_cacheData;

  // The cache holds whatever word the last completed access left in the SRAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cacheValid <= 1'b0;
      r_cacheTag   <= '0;
      r_cacheData  <= '0;
    end else if ((r_state == RD) && w_last && !r_isWrite) begin
      r_cacheValid <= 1'b1;
      r_cacheTag   <= r_adr;
      r_cacheData  <= sram_dat_in;
    end else if (r_state == WR_HOLD) begin
      r_cacheValid <= 1'b1;
      r_cacheTag   <= r_adr;
      r_cacheData  <= r_word;
    end
  end
`else
  assign w_rdHit     = 1'b0;
  assign w_wrHit     = 1'b0;
  assign w_cacheWord = 16'h0000;
`endif

  // ACK doubles as an accept state so back-to-back requests need no idle cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_isWrite <= 1'b0;
      r_lane    <= 1'b0;
      r_wdata   <= '0;
      r_word    <= '0;
      r_adr     <= '0;
      r_datOut  <= '0;
      r_datOe   <= 1'b0;
      r_csN     <= 1'b1;
      r_oeN     <= 1'b1;
      r_weN     <= 1'b1;
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (w_accept) begin
        r_adr     <= bus.req_addr[18:1];
        r_lane    <= bus.req_addr[0];
        r_wdata   <= bus.req_wdata;
        r_isWrite <= bus.req_wr;
        r_cnt     <= '0;
        if (w_rdHit) begin
          r_state <= ACK;
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_rdata <= bus.req_addr[0] ? w_cacheWord[15:8] : w_cacheWord[7:0];
        end else if (w_wrHit) begin
          r_state  <= WR_SETUP;
          r_busy   <= 1'b1;
          r_csN    <= 1'b0;
          r_datOe  <= 1'b1;
          r_datOut <= mergeByte(w_cacheWord, bus.req_addr[0], bus.req_wdata);
          r_word   <= mergeByte(w_cacheWord, bus.req_addr[0], bus.req_wdata);
        end else begin
          r_state <= RD;
          r_busy  <= 1'b1;
          r_csN   <= 1'b0;
          r_oeN   <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          RD: begin
            if (!w_last) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (r_isWrite) begin
              r_state  <= WR_SETUP;
              r_oeN    <= 1'b1;
              r_datOe  <= 1'b1;
              r_datOut <= w_fetchMerged;
              r_word   <= w_fetchMerged;
              r_cnt    <= '0;
            end else begin
              r_state <= ACK;
              r_csN   <= 1'b1;
              r_oeN   <= 1'b1;
              r_ack   <= 1'b1;
              r_busy  <= 1'b0;
              r_word  <= sram_dat_in;
              r_rdata <= r_lane ? sram_dat_in[15:8] : sram_dat_in[7:0];
            end
          end
          WR_SETUP: begin
            r_state <= WR_PULSE;
            r_weN   <= 1'b0;
            r_cnt   <= '0;
          end
          WR_PULSE: begin
            if (w_last) begin
              r_state <= WR_HOLD;
              r_weN   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          WR_HOLD: begin
            r_state <= ACK;
            r_csN   <= 1'b1;
            r_datOe <= 1'b0;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
            r_rdata <= r_wdata;
          end
          ACK:     r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign sram_adr      = r_adr;
  assign sram_dat_out  = r_datOut;
  assign sram_dat_oe   = r_datOe;
  assign sram_cs_n     = r_csN;
  assign sram_oe_n     = r_oeN;
  assign sram_we_n     = r_weN;
  assign bus.req_rdata = r_rdata;
  assign bus.req_ack   = r_ack;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Scoreboard bench for sram_byte_bridge: a behavioural SRAM, a word-level reference
// memory and cache model, and a monitor that checks every ack and strobe pulse.
module tb_sram_byte_bridge;

  localparam int W = 2;
`ifdef SRAM_WORD_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] rdata;
    int         acc;
    int         lat;
    int         cs;
    int         oe;
    int         we;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [17:0] sram_adr;
  logic [15:0] sram_dat_in;
  logic [15:0] sram_dat_out;
  logic        sram_dat_oe;
  logic        sram_cs_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  sram_byte_bridge_if bus ();

  sram_byte_bridge #(.WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .sram_adr     (sram_adr),
    .sram_dat_in  (sram_dat_in),
    .sram_dat_out (sram_dat_out),
    .sram_dat_oe  (sram_dat_oe),
    .sram_cs_n    (sram_cs_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n)
  );

  int          nTests = 0;
  int          nFail = 0;
  int          cycleCnt = 0;
  int          lastAckCycle = -1;
  exp_t        sbQ[$];
  logic [15:0] sramMem [0:511];
  logic [15:0] refMem [0:511];
  logic        refValid = 1'b0;
  logic [17:0] refTag = '0;

  function automatic logic [15:0] initWord(input int i);
    if (i == 'h123) return 16'hBEEF;
    if (i == 'h040) return 16'h1234;
    return 16'((i * 40503) ^ 32'h0000A5C3);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt++;

  // Asynchronous SRAM: reads while CS and OE are low, latches data at the end of WE.
  assign sram_dat_in = (!sram_cs_n && !sram_oe_n) ? sramMem[sram_adr[8:0]] : 16'hDEAD;

  initial begin
    for (int i = 0; i < 512; i++) sramMem[i] = initWord(i);
    forever begin
      @(posedge sram_we_n);
      if (reset_n === 1'b1 && sram_cs_n === 1'b0 && sram_dat_oe === 1'b1)
        sramMem[sram_adr[8:0]] = sram_dat_out;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Reference: byte accesses on a word memory, plus the last-touched word as the cache.
  task automatic pushExpected(input logic [18:0] addr, input logic [7:0] wd, input logic wr,
                              input int acc);
    exp_t        e;
    logic [8:0]  wa;
    logic [15:0] word;
    logic        hit;
    wa   = addr[9:1];
    hit  = CACHE_EN && refValid && (refTag == addr[18:1]);
    word = refMem[wa];
    e.acc = acc;
    if (wr) begin
      if (addr[0]) word[15:8] = wd;
      else         word[7:0]  = wd;
      refMem[wa] = word;
      e.rdata = wd;
      e.lat   = hit ? W + 3 : 2 * W + 3;
      e.cs    = hit ? W + 2 : 2 * W + 2;
      e.oe    = hit ? 0 : W;
      e.we    = W;
    end else begin
      e.rdata = addr[0] ? word[15:8] : word[7:0];
      e.lat   = hit ? 1 : W + 1;
      e.cs    = hit ? 0 : W;
      e.oe    = hit ? 0 : W;
      e.we    = 0;
    end
    refValid = 1'b1;
    refTag   = addr[18:1];
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [18:0] addr, input logic [7:0] wd, input logic rd,
                               input logic wr, output int accCyc);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    while (bus.busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("accept_timeout", 32'(guard), 32'd0);
      bus.req_rd = 1'b0;
      bus.req_wr = 1'b0;
      accCyc = -1;
      return;
    end
    accCyc = cycleCnt;
    pushExpected(addr, wd, wr, accCyc);
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (sbQ.size() > 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sbQ.size() > 0) checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cs_n"}, 32'(sram_cs_n), 32'd1);
    checkOutput({tag, "_oe_n"}, 32'(sram_oe_n), 32'd1);
    checkOutput({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    checkOutput({tag, "_dat_oe"}, 32'(sram_dat_oe), 32'd0);
    checkOutput({tag, "_adr"}, 32'(sram_adr), 32'd0);
    checkOutput({tag, "_dat_out"}, 32'(sram_dat_out), 32'd0);
    checkOutput({tag, "_rdata"}, 32'(bus.req_rdata), 32'd0);
    checkOutput({tag, "_ack"}, 32'(bus.req_ack), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Monitor: strobe pulse shapes every cycle, scoreboard pop on every ack.
  int   csCnt, oeCnt, weCnt, oeRun, weRun;
  logic prevWe, prev2We, prevOe, prevDatOe, prev2DatOe;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n !== 1'b1) begin
      csCnt = 0; oeCnt = 0; weCnt = 0; oeRun = 0; weRun = 0;
      prevWe = 1'b1; prev2We = 1'b1; prevOe = 1'b1; prevDatOe = 1'b0; prev2DatOe = 1'b0;
    end else begin
      if (sram_cs_n === 1'b0) csCnt++;
      if (sram_oe_n === 1'b0) begin oeCnt++; oeRun++; end
      if (sram_we_n === 1'b0) begin weCnt++; weRun++; end
      if (sram_oe_n === 1'b1 && prevOe === 1'b0) begin
        checkOutput("oe_pulse_width", 32'(oeRun), 32'(W));
        oeRun = 0;
      end
      if (sram_we_n === 1'b1 && prevWe === 1'b0) begin
        checkOutput("we_pulse_width", 32'(weRun), 32'(W));
        weRun = 0;
      end
      if (sram_we_n === 1'b0)
        checkOutput("we_low_bus_state", {29'd0, sram_cs_n, sram_oe_n, sram_dat_oe}, 32'b011);
      if (sram_we_n === 1'b0 && prevWe === 1'b1)
        checkOutput("datoe_lead", {30'd0, prev2DatOe, prevDatOe}, 32'b01);
      if (sram_dat_oe === 1'b0 && prevDatOe === 1'b1)
        checkOutput("datoe_trail", {30'd0, prev2We, prevWe}, 32'b01);
      if (bus.req_ack === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("ack_rdata", 32'(bus.req_rdata), 32'(e.rdata));
          checkOutput("ack_latency", 32'(cycleCnt - e.acc), 32'(e.lat));
          checkOutput("cs_low_cycles", 32'(csCnt), 32'(e.cs));
          checkOutput("oe_low_cycles", 32'(oeCnt), 32'(e.oe));
          checkOutput("we_low_cycles", 32'(weCnt), 32'(e.we));
        end
        lastAckCycle = cycleCnt;
        csCnt = 0; oeCnt = 0; weCnt = 0;
      end
      prev2We = prevWe;       prevWe = sram_we_n;
      prev2DatOe = prevDatOe; prevDatOe = sram_dat_oe;
      prevOe = sram_oe_n;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          accA, accB, badWords;
    logic [18:0] addr, lastAddr;
    logic        rd, wr;
    int          opSel;

    for (int i = 0; i < 512; i++) refMem[i] = initWord(i);
    reset_n       = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Lane select on word 0x123.
    applyStimulus(19'h00246, 8'h00, 1'b1, 1'b0, accA);
    applyStimulus(19'h00247, 8'h00, 1'b1, 1'b0, accA);
    waitIdle();

    // Read-modify-write of the high byte of word 0x40.
    applyStimulus(19'h00081, 8'hAB, 1'b0, 1'b1, accA);
    waitIdle();
    checkOutput("rmw_word40", 32'(sramMem['h40]), 32'h0000AB34);

    // Simultaneous rd and wr is a write.
    applyStimulus(19'h00000, 8'h5A, 1'b1, 1'b1, accA);
    waitIdle();
    checkOutput("rdwr_word0", 32'(sramMem[0]), 32'({initWord(0) >> 8, 8'h5A}));

    // Read queued behind a write is accepted on the write's ACK edge.
    applyStimulus(19'h00300, 8'hC3, 1'b0, 1'b1, accA);
    applyStimulus(19'h00302, 8'h00, 1'b1, 1'b0, accB);
    checkOutput("b2b_accept_cycle", 32'(accB), 32'(lastAckCycle));
    @(negedge clk);
    checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
    waitIdle();

    // Cache sequence: same word read twice, then written.
    applyStimulus(19'h00010, 8'h00, 1'b1, 1'b0, accA);
    applyStimulus(19'h00011, 8'h00, 1'b1, 1'b0, accA);
    applyStimulus(19'h00010, 8'h77, 1'b0, 1'b1, accA);
    waitIdle();

    // Reset in the middle of a read, then a normal read.
    @(negedge clk);
    bus.req_addr = 19'h00080;
    bus.req_rd   = 1'b1;
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midrd_reset");
    refValid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(19'h00246, 8'h00, 1'b1, 1'b0, accA);
    waitIdle();

    // Randomised traffic with address reuse to exercise cache hits and back-to-back.
    lastAddr = 19'h00010;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      opSel = $urandom_range(0, 9);
      rd = (opSel < 5) || (opSel == 9);
      wr = (opSel >= 5);
      if ($urandom_range(0, 9) < 4) addr = {lastAddr[18:1], 1'($urandom_range(0, 1))};
      else                          addr = 19'($urandom_range(0, 1023));
      applyStimulus(addr, 8'($urandom_range(0, 255)), rd, wr, accA);
      lastAddr = addr;
    end
    waitIdle();

    badWords = 0;
    for (int i = 0; i < 512; i++) begin
      if (sramMem[i] !== refMem[i]) begin
        if (badWords == 0)
          $display("[TB] first differing word %0h: sram %0h reference %0h", i, sramMem[i], refMem[i]);
        badWords++;
      end
    end
    checkOutput("memory_image", 32'(badWords), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
